// File: rtl/div_pkg.sv
// div_pkg: state encoding, div_op bit positions and default width for the EXE divide controller
package div_pkg;
  localparam int DW = 32;
  localparam int DIV_W  = 0;
  localparam int DIV_WU = 1;
  localparam int MOD_W  = 2;
  localparam int MOD_WU = 3;
  typedef enum logic [1:0] {DIV_IDLE, DIV_SEND, DIV_WAIT, DIV_DONE} div_state_e;
endpackage

// File: rtl/axis_src_chan.sv
// axis_src_chan: tvalid/sent tracker for one AXI-Stream operand channel
module axis_src_chan (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic tready,
  output logic tvalid,
  output logic sent
);
  logic tvalid_q, tvalid_d, sent_q, sent_d, hs;
  assign hs = tvalid_q & tready;
  always_comb begin
    tvalid_d = start ? 1'b1 : hs ? 1'b0 : tvalid_q;
    sent_d   = start ? 1'b0 : hs ? 1'b1 : sent_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tvalid_q <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      sent_q   <= sent_d;
    end
  end
  assign tvalid = tvalid_q;
  assign sent   = sent_q;
endmodule

// File: rtl/exe_div_ctrl.sv
// exe_div_ctrl: sequences signed/unsigned divider IPs for div.w/div.wu/mod.w/mod.wu and stalls EXE until done
module exe_div_ctrl #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exe_valid,
  input  logic [3:0]      div_op,
  input  logic [DW-1:0]   src1,
  input  logic [DW-1:0]   src2,
  input  logic            mem_allowin,
  output logic [DW-1:0]   div_dividend,
  output logic [DW-1:0]   div_divisor,
  output logic            s_dvd_tvalid,
  input  logic            s_dvd_tready,
  output logic            s_dvs_tvalid,
  input  logic            s_dvs_tready,
  input  logic            s_dout_tvalid,
  input  logic [2*DW-1:0] s_dout_tdata,
  output logic            u_dvd_tvalid,
  input  logic            u_dvd_tready,
  output logic            u_dvs_tvalid,
  input  logic            u_dvs_tready,
  input  logic            u_dout_tvalid,
  input  logic [2*DW-1:0] u_dout_tdata,
  output logic [DW-1:0]   div_result,
  output logic            exe_readygo
);
  import div_pkg::*;
  div_state_e state_q, state_d;
  logic is_signed_q, is_signed_d, is_mod_q, is_mod_d;
  logic [DW-1:0] dvd_q, dvd_d, dvs_q, dvs_d, res_q, res_d;
  logic req, start, sel_s;
  logic s_dvd_sent, s_dvs_sent, u_dvd_sent, u_dvs_sent;
  logic dvd_done, dvs_done, dout_vld;
  logic [2*DW-1:0] dout;
  assign req   = exe_valid & |div_op;
  assign sel_s = div_op[DIV_W] | div_op[MOD_W];
  assign start = (state_q == DIV_IDLE) & req;
  axis_src_chan u_s_dvd (.clk(clk), .reset(reset), .start(start & sel_s), .tready(s_dvd_tready), .tvalid(s_dvd_tvalid), .sent(s_dvd_sent));
  axis_src_chan u_s_dvs (.clk(clk), .reset(reset), .start(start & sel_s), .tready(s_dvs_tready), .tvalid(s_dvs_tvalid), .sent(s_dvs_sent));
  axis_src_chan u_u_dvd (.clk(clk), .reset(reset), .start(start & ~sel_s), .tready(u_dvd_tready), .tvalid(u_dvd_tvalid), .sent(u_dvd_sent));
  axis_src_chan u_u_dvs (.clk(clk), .reset(reset), .start(start & ~sel_s), .tready(u_dvs_tready), .tvalid(u_dvs_tvalid), .sent(u_dvs_sent));
  // a channel counts as done if it handshook earlier or is handshaking now
  assign dvd_done = is_signed_q ? (s_dvd_sent | (s_dvd_tvalid & s_dvd_tready))
                                : (u_dvd_sent | (u_dvd_tvalid & u_dvd_tready));
  assign dvs_done = is_signed_q ? (s_dvs_sent | (s_dvs_tvalid & s_dvs_tready))
                                : (u_dvs_sent | (u_dvs_tvalid & u_dvs_tready));
  assign dout_vld = is_signed_q ? s_dout_tvalid : u_dout_tvalid;
  assign dout     = is_signed_q ? s_dout_tdata : u_dout_tdata;
  always_comb begin
    state_d     = state_q;
    is_signed_d = is_signed_q;
    is_mod_d    = is_mod_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    res_d       = res_q;
    case (state_q)
      DIV_IDLE: if (req) begin
        state_d     = DIV_SEND;
        dvd_d       = src1;
        dvs_d       = src2;
        is_signed_d = sel_s;
        is_mod_d    = div_op[MOD_W] | div_op[MOD_WU];
      end
      DIV_SEND: if (dvd_done & dvs_done) state_d = DIV_WAIT;
      DIV_WAIT: if (dout_vld) begin
        state_d = DIV_DONE;
        res_d   = is_mod_q ? dout[DW-1:0] : dout[2*DW-1:DW];
      end
      DIV_DONE: if (mem_allowin) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      is_signed_q <= 1'b0;
      is_mod_q    <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      is_signed_q <= is_signed_d;
      is_mod_q    <= is_mod_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      res_q       <= res_d;
    end
  end
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign div_result   = res_q;
  assign exe_readygo  = ~req | (state_q == DIV_DONE);
  a_stable: assert property (@(posedge clk) disable iff (reset)
    !exe_readygo |=> ($stable(exe_valid) && $stable(div_op)));
  a_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(div_op));
endmodule

// File: tb/tb_exe_div_ctrl.sv
// tb_exe_div_ctrl: directed scoreboard bench with behavioural divider IPs around exe_div_ctrl
module tb_exe_div_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        exe_valid, mem_allowin;
  logic [3:0]  div_op;
  logic [31:0] src1, src2, div_dividend, div_divisor, div_result;
  logic        s_dvd_tvalid, s_dvd_tready, s_dvs_tvalid, s_dvs_tready, s_dout_tvalid;
  logic        u_dvd_tvalid, u_dvd_tready, u_dvs_tvalid, u_dvs_tready, u_dout_tvalid;
  logic [63:0] s_dout_tdata, u_dout_tdata;
  logic        exe_readygo;
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  exe_div_ctrl #(.DW(32)) dut (
    .clk(clk), .reset(reset), .exe_valid(exe_valid), .div_op(div_op),
    .src1(src1), .src2(src2), .mem_allowin(mem_allowin),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .s_dvd_tvalid(s_dvd_tvalid), .s_dvd_tready(s_dvd_tready),
    .s_dvs_tvalid(s_dvs_tvalid), .s_dvs_tready(s_dvs_tready),
    .s_dout_tvalid(s_dout_tvalid), .s_dout_tdata(s_dout_tdata),
    .u_dvd_tvalid(u_dvd_tvalid), .u_dvd_tready(u_dvd_tready),
    .u_dvs_tvalid(u_dvs_tvalid), .u_dvs_tready(u_dvs_tready),
    .u_dout_tvalid(u_dout_tvalid), .u_dout_tdata(u_dout_tdata),
    .div_result(div_result), .exe_readygo(exe_readygo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // drives one divide, plays both IPs, and checks timing, handshakes and the result
  task automatic run_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int extra, input int hold, input logic [31:0] expv);
    logic sgn, dv, sv, dvs_rdy;
    logic signed [31:0] sa, sb;
    logic [63:0] td;
    logic [31:0] e;
    int k, hs_d, hs_s, dout_at, go, nv_d, nv_s, n_other;
    sgn = op[0] | op[2];
    sa = a;
    sb = b;
    td = (b == 0) ? {32'hFFFFFFFF, a} : sgn ? {sa / sb, sa % sb} : {a / b, a % b};
    exe_valid = 1'b1;
    div_op = op;
    src1 = a;
    src2 = b;
    mem_allowin = 1'b1;
    s_dout_tdata = sgn ? td : 64'hDEADBEEF_CAFEF00D;
    u_dout_tdata = sgn ? 64'hDEADBEEF_CAFEF00D : td;
    exp_q.push_back(expv);
    #1;
    chk("readygo_on_request", exe_readygo, 0);
    k = 0; hs_d = -1; hs_s = -1; dout_at = -1; go = -1; nv_d = 0; nv_s = 0; n_other = 0;
    while (go < 0 && k < 60) begin
      @(negedge clk);
      k++;
      dvs_rdy = (k > extra);
      s_dvd_tready = 1'b1;
      u_dvd_tready = 1'b1;
      s_dvs_tready = dvs_rdy;
      u_dvs_tready = dvs_rdy;
      s_dout_tvalid = sgn ? (k == dout_at) : (k == 3);
      u_dout_tvalid = sgn ? (k == 3) : (k == dout_at);
      #1;
      if (exe_readygo) go = k;
      dv = sgn ? s_dvd_tvalid : u_dvd_tvalid;
      sv = sgn ? s_dvs_tvalid : u_dvs_tvalid;
      if (sgn ? (u_dvd_tvalid | u_dvs_tvalid) : (s_dvd_tvalid | s_dvs_tvalid)) n_other++;
      if (dv) begin nv_d++; hs_d = k; end
      if (sv) nv_s++;
      if (sv && dvs_rdy) hs_s = k;
      if (k == 1) begin
        chk("dividend_reg", div_dividend, a);
        chk("divisor_reg", div_divisor, b);
      end
      if (hs_d > 0 && hs_s > 0 && dout_at < 0) dout_at = ((hs_d > hs_s) ? hs_d : hs_s) + 1 + lat;
    end
    s_dout_tvalid = 1'b0;
    u_dout_tvalid = 1'b0;
    chk("readygo_cycle", go, 3 + extra + lat);
    chk("dvd_tvalid_cycles", nv_d, 1);
    chk("dvs_tvalid_cycles", nv_s, extra + 1);
    chk("other_ip_tvalid", n_other, 0);
    e = exp_q.pop_front();
    chk("div_result", div_result, e);
    mem_allowin = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk("done_hold_readygo", exe_readygo, 1);
      chk("done_hold_result", div_result, e);
    end
    mem_allowin = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_after_done", exe_readygo, 0);
    chk("idle_tvalids", {s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 0);
    exe_valid = 1'b0;
    div_op = 4'b0000;
  endtask

  initial begin
    reset = 1'b1;
    exe_valid = 1'b0;
    div_op = 4'b0000;
    src1 = '0;
    src2 = '0;
    mem_allowin = 1'b1;
    {s_dvd_tready, s_dvs_tready, u_dvd_tready, u_dvs_tready} = 4'b1111;
    s_dout_tvalid = 1'b0;
    u_dout_tvalid = 1'b0;
    s_dout_tdata = '0;
    u_dout_tdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_result", div_result, 0);
    chk("reset_dividend", div_dividend, 0);
    chk("reset_tvalids", {s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 0);
    chk("reset_readygo", exe_readygo, 1);
    reset = 1'b0;
    run_div(4'b0001, 32'hFFFFFFF9, 32'd2, 8, 0, 0, 32'hFFFFFFFD);
    run_div(4'b0100, 32'hFFFFFFF9, 32'd2, 4, 0, 0, 32'hFFFFFFFF);
    run_div(4'b1000, 32'hFFFFFFFF, 32'h10, 2, 0, 0, 32'h0000000F);
    run_div(4'b0010, 32'hFFFFFFFF, 32'd2, 3, 3, 5, 32'h7FFFFFFF);
    exe_valid = 1'b1;
    div_op = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("nondiv_readygo", exe_readygo, 1);
      chk("nondiv_tvalids", {s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 0);
    end
    {s_dvd_tready, s_dvs_tready, u_dvd_tready, u_dvs_tready} = 4'b1111;
    div_op = 4'b0001;
    src1 = 32'd55;
    src2 = 32'd5;
    s_dout_tdata = {32'd11, 32'd0};
    repeat (4) @(negedge clk);
    #1;
    chk("midwait_readygo", exe_readygo, 0);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_result", div_result, 0);
    chk("async_rst_dividend", div_dividend, 0);
    chk("async_rst_divisor", div_divisor, 0);
    chk("async_rst_tvalids", {s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid}, 0);
    @(negedge clk);
    exe_valid = 1'b0;
    div_op = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_readygo", exe_readygo, 1);
    run_div(4'b0001, 32'd100, 32'd7, 3, 0, 0, 32'd14);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exe_div_ctrl.md
# exe_div_ctrl

Sequencing controller for the EXE-stage integer divide path. Accepts `div.w`, `div.wu`, `mod.w` and `mod.wu` operations from EXE and drives the AXI-Stream operand handshakes of two divider IPs, one signed and one unsigned. It waits for the quotient/remainder, holds it stable, and stalls EXE through `exe_readygo` until the result is ready. It sits beside the ALU in EXE; for non-divide instructions it is transparent.

## Interface
Parameters:
- `DW`, 32, operand width.

Ports (reset is asynchronous and active-high; `clk` is the single clock):
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `exe_valid`  in  1  EXE holds a valid instruction
- `div_op`  in  4  one-hot `{mod_wu, mod_w, div_wu, div_w}` = `alu_op[18:15]`
- `src1`  in  DW  dividend
- `src2`  in  DW  divisor
- `mem_allowin`  in  1  MEM accepts the EXE instruction this cycle
- `div_dividend`  out  DW  dividend to both IPs (registered)
- `div_divisor`  out  DW  divisor to both IPs (registered)
- `s_dvd_tvalid`  out  1  signed IP dividend valid
- `s_dvd_tready`  in  1  signed IP dividend ready
- `s_dvs_tvalid`  out  1  signed IP divisor valid
- `s_dvs_tready`  in  1  signed IP divisor ready
- `s_dout_tvalid`  in  1  signed IP result valid
- `s_dout_tdata`  in  2*DW  signed IP result, `{quotient, remainder}`
- `u_dvd_tvalid`, `u_dvd_tready`, `u_dvs_tvalid`, `u_dvs_tready`, `u_dout_tvalid`, `u_dout_tdata`: unsigned IP, same widths and meanings as the signed set
- `div_result`  out  DW  selected quotient or remainder
- `exe_readygo`  out  1  EXE may advance

## Operation
- States: IDLE, SEND, WAIT, DONE.
- IDLE, with `exe_valid & |div_op`:
  - Register `src1`/`src2`, `is_signed = div_op[0]|div_op[2]`, and `is_mod = div_op[2]|div_op[3]`.
  - Go to SEND.
- SEND:
  - Assert both tvalids of the selected IP only; the other IP's tvalids stay 0.
  - Each channel has its own `sent` flag. A channel's tvalid drops the cycle after its own handshake (tvalid & tready); the other channel keeps waiting.
  - When both channels have handshaken, go to WAIT. Simultaneous handshakes are allowed and take one cycle.
- WAIT:
  - On `dout_tvalid` of the selected IP, register `div_result` = `is_mod ? tdata[DW-1:0] : tdata[2*DW-1:DW]`, then go to DONE.
  - `dout_tvalid` from the unselected IP is ignored.
- DONE:
  - `div_result` is held stable.
  - With `mem_allowin`, go to IDLE. The same EXE instruction is never restarted.
- `exe_readygo = ~(exe_valid & |div_op) | (state == DONE)`.
- Divide by zero: whatever the IP returns is passed through unmodified (architecturally undefined).
- `exe_valid` and `div_op` must stay stable while `exe_readygo` = 0 (pipeline invariant, assertion-checked). `div_op` with more than one bit set is illegal and asserted.

## Timing
- Reset (asynchronous, any state): state returns to IDLE; every tvalid, `sent` flag, `div_result`, `div_dividend` and `div_divisor` goes to 0. The IPs take `aresetn = ~reset`, so no stale result survives.
- Request seen at cycle 0 → tvalids high at cycle 1 → with tready high, WAIT from cycle 2 → `dout_tvalid` at cycle 2+L → DONE and `exe_readygo` = 1 at cycle 3+L.
- tvalid never drops before its handshake, and the operand registers do not change while any tvalid is high (AXI-Stream rule).
- A back-to-back divide enters IDLE → SEND on the cycle after the DONE → IDLE transition. There is no bypass from DONE straight to SEND.

## Structure
- Package `div_pkg` holds: the state enum (`DIV_IDLE`, `DIV_SEND`, `DIV_WAIT`, `DIV_DONE`), the `div_op` bit indices (`DIV_W`=0, `DIV_WU`=1, `MOD_W`=2, `MOD_WU`=3), and `DW`.
- Sub-module `axis_src_chan` (tvalid/sent tracker for one AXI-Stream operand channel) is instantiated four times, one per signed/unsigned dividend and divisor channel.
- Everything else is a single FSM plus result mux in `exe_div_ctrl`.

## Test plan
- `div_w`, src1=0xFFFFFFF9 (−7), src2=2, IP latency 8 → only the signed tvalids fire; `div_result`=0xFFFFFFFD; `exe_readygo` rises at cycle 11.
- `mod_w` (−7, 2) → 0xFFFFFFFF. `mod_wu` (0xFFFFFFFF, 0x10) → 0x0000000F.
- `div_wu` 0xFFFFFFFF/2, divisor tready held low 3 extra cycles → dividend tvalid drops after 1 cycle, divisor tvalid stays high 4 cycles; result 0x7FFFFFFF.
- In DONE with `mem_allowin`=0 for 5 cycles → `div_result` stable, still DONE; IDLE the cycle after `mem_allowin`=1. A non-div op → `exe_readygo`=1 and all tvalids 0.
- `reset` pulsed mid-WAIT → all outputs 0 asynchronously; a following `div_w` 100/7 → 14 with no stale result.
